key_press_emu: RTL and testbench
================================

Name: key_press_emu

Overview:
- Stimulus-side counterpart of the FSM key debouncer: emulates mechanical push-buttons by driving active-low key lines with a press bounce, a stable hold and a release bounce.
- Bounce is pseudo-random.
- Feeds the debouncer's key_in, in simulation or on-board self-test, so debounce timing is exercised without physical buttons.
- Issued by a controller via a start pulse plus a key-select mask.

Parameters:
- KEY_W, 3, number of key lines driven
- BOUNCE_CYC, 16, length in clk cycles of each bounce phase (press and release), >=2
- HOLD_CYC, 100, length in clk cycles of the stable-low hold phase, >=1
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to emulate a press/release sequence
- key_sel  input  KEY_W  mask of keys to press, sampled with start
- key_out  output  KEY_W  emulated key lines, active-low, idle all-ones
- busy  output  1  high from the cycle after an accepted start through DONE
- done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: key_out all ones; busy 0; done 0; state IDLE; phase counter 0; LFSR SEED.
- All outputs are registered.
- State machine: IDLE -> P_BNC -> HOLD -> R_BNC -> DONE -> IDLE.
- IDLE:
  - Accept start when start=1 and key_sel!=0.
  - On accept, latch sel_q=key_sel, clear the counter and go to P_BNC.
  - start with key_sel=0 is ignored; stay IDLE with no done pulse.
- P_BNC:
  - Lasts exactly BOUNCE_CYC cycles.
  - Selected lines = lfsr[0] each cycle. The final cycle is forced 0.
  - Unselected lines stay 1.
- HOLD:
  - Lasts exactly HOLD_CYC cycles.
  - Selected lines 0, unselected 1.
- R_BNC:
  - Lasts exactly BOUNCE_CYC cycles.
  - Selected lines = lfsr[0] each cycle. The final cycle is forced 1.
- DONE:
  - One cycle; done=1, key_out all ones, busy still 1.
  - Next cycle: IDLE, busy=0.
- Latency: start sampled at edge N gives busy=1 and the first P_BNC value on key_out after edge N. The total busy window is 2*BOUNCE_CYC+HOLD_CYC+1 cycles.
- Phase counter:
  - Width $clog2(max(BOUNCE_CYC,HOLD_CYC)+1).
  - Cleared on every state change; compared against (length-1) to leave the phase.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11 (x^16+x^14+x^13+x^11+1).
  - Steps every cycle while not IDLE; holds in IDLE.
  - Never reaches 0.
- start while busy is ignored; no queueing, sel_q is unchanged.
- key_sel changes while busy have no effect.
- rst mid-sequence: on the next edge all outputs return to reset values, and no done pulse is emitted.
- Simultaneous rst and start: rst wins; the start is dropped.

Optional Feature:
- Macro: KEY_EMU_BOUNCE_EN.
- Defined: bounce phases use LFSR-driven toggling as specified above.
- Not defined:
  - Bounce phases drive clean levels: selected lines 0 for all of P_BNC and 1 for all of R_BNC.
  - Phase lengths, busy/done timing and port list are identical.
  - The LFSR is still present but does not affect key_out.

Test Plan:
- Reset hold 3 cycles, then release -> key_out=3'b111, busy=0, done=0 through idle; a start during reset produces nothing.
- BOUNCE_CYC=16, HOLD_CYC=100, start with key_sel=3'b010 -> busy high for 133 cycles.
  - Bits 0 and 2 stay 1 throughout.
  - Bit 1 is 0 for the final P_BNC cycle and all 100 HOLD cycles, and 1 in the last R_BNC cycle.
  - done pulses once at cycle 133.
- With KEY_EMU_BOUNCE_EN and SEED=16'hACE1, record bit 1 during P_BNC -> matches the LFSR reference model bit-for-bit, with at least one 0->1 toggle. Without the macro -> bit 1 is 0 for all 16 cycles.
- Second start asserted at cycle 50 of a running sequence with key_sel=3'b001 -> ignored; the sequence and mask are unchanged; exactly one done.
- start with key_sel=3'b000 -> busy stays 0, key_out=3'b111, no done.
- rst pulsed at HOLD cycle 40 -> next cycle key_out=3'b111, busy=0, no done. A new start afterwards reproduces the first-run bounce pattern, since the LFSR is reseeded.

Source files
------------

// File: rtl/key_press_emu.sv
// rtl/key_press_emu.sv - emulated push-button press/hold/release with bounce (option: KEY_EMU_BOUNCE_EN)
module key_press_emu #(
    parameter int          KEY_W      = 3,
    parameter int          BOUNCE_CYC = 16,
    parameter int          HOLD_CYC   = 100,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_sel,
    output logic [KEY_W-1:0] key_out,
    output logic             busy,
    output logic             done
);

    localparam int          MAX_LEN  = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
    localparam int          CW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] B_LAST = CW'(BOUNCE_CYC - 1);
    localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYC - 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P_BNC = 3'd1,
        HOLD  = 3'd2,
        R_BNC = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [KEY_W-1:0] sel_q, sel_d;
    logic [KEY_W-1:0] key_d;
    logic             busy_d, done_d;
    logic             accept;
    logic             bnc_bit;

    assign accept = (state_q == IDLE) && start && (key_sel != '0);

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lfsr_q  <= SEED_EFF;
            sel_q   <= '0;
            key_out <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            sel_q   <= sel_d;
            key_out <= key_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, phase counter, LFSR and mask latch
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)          state_d = P_BNC;
            P_BNC:   if (cnt_q == B_LAST) state_d = HOLD;
            HOLD:    if (cnt_q == H_LAST) state_d = R_BNC;
            R_BNC:   if (cnt_q == B_LAST) state_d = DONE;
            DONE:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase

        if (state_d != state_q || state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Taps 16,14,13,11; the value after stepping feeds this cycle's bounce bit
        if (state_q != IDLE) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end else begin
            lfsr_d = lfsr_q;
        end

        sel_d = accept ? key_sel : sel_q;
    end

    // Output values for the cycle being entered
    always_comb begin
        key_d   = '1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        bnc_bit = 1'b1;
        unique case (state_d)
            IDLE: begin
                key_d = '1;
            end
            P_BNC: begin
                busy_d = 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
                bnc_bit = (cnt_d == B_LAST) ? 1'b0 : lfsr_d[0];
`else
                bnc_bit = 1'b0;
`endif
                key_d = ~sel_d | {KEY_W{bnc_bit}};
            end
            HOLD: begin
                busy_d = 1'b1;
                key_d  = ~sel_d;
            end
            R_BNC: begin
                busy_d = 1'b1;
`ifdef KEY_EMU_BOUNCE_EN
                bnc_bit = (cnt_d == B_LAST) ? 1'b1 : lfsr_d[0];
`else
                bnc_bit = 1'b1;
`endif
                key_d = ~sel_d | {KEY_W{bnc_bit}};
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
                key_d  = '1;
            end
            default: begin
                key_d = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_key_press_emu.sv
// tb/tb_key_press_emu.sv - self-checking bench for key_press_emu
module tb_key_press_emu;

    localparam int          W     = 3;
    localparam int          B     = 16;
    localparam int          H     = 100;
    localparam logic [15:0] SD    = 16'hACE1;
    localparam int          TOTAL = 2 * B + H + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] key_sel;
    logic [W-1:0] key_out;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] mdl_lfsr;
    logic [63:0] pat_first, pat_now;

    typedef struct {
        logic [2:0] sel;
        int         extra_at;
        logic [2:0] extra_sel;
        int         rst_at;
        int         exp_busy;
        int         exp_done;
    } vec_t;
    vec_t tbl[6];

    key_press_emu #(.KEY_W(W), .BOUNCE_CYC(B), .HOLD_CYC(H), .SEED(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .key_sel(key_sel),
        .key_out(key_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference: busy index j -> phase by arithmetic on the phase lengths
    function automatic logic [2:0] exp_key(input int j, input logic [2:0] sel, input logic [15:0] lf);
        logic b;
        if (j < B) begin
`ifdef KEY_EMU_BOUNCE_EN
            b = (j == B - 1) ? 1'b0 : lf[0];
`else
            b = 1'b0;
`endif
            return ~sel | {3{b}};
        end else if (j < B + H) begin
            return ~sel;
        end else if (j < 2 * B + H) begin
`ifdef KEY_EMU_BOUNCE_EN
            b = (j - B - H == B - 1) ? 1'b1 : lf[0];
`else
            b = 1'b1;
`endif
            return ~sel | {3{b}};
        end
        return 3'b111;
    endfunction

    task automatic run_seq(input logic [2:0] sel, input int extra_at, input logic [2:0] extra_sel,
                           input int rst_at, output int busy_cnt, output int done_cnt,
                           output logic [63:0] pat);
        logic       acc;
        logic [2:0] ek;
        logic       eb, ed;
        busy_cnt = 0;
        done_cnt = 0;
        pat      = '0;
        acc      = (sel != 3'b000);
        @(negedge clk);
        start   = 1'b1;
        key_sel = sel;
        @(negedge clk);
        start   = 1'b0;
        key_sel = 3'($urandom);
        for (int j = 0; j < TOTAL + 3; j++) begin
            if (acc && j < TOTAL) begin
                ek = exp_key(j, sel, mdl_lfsr);
                eb = 1'b1;
                ed = (j == TOTAL - 1);
            end else begin
                ek = 3'b111;
                eb = 1'b0;
                ed = 1'b0;
            end
            check("key_out", 32'(key_out), 32'(ek));
            check("busy", 32'(busy), 32'(eb));
            check("done", 32'(done), 32'(ed));
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (acc && j < B) pat[j] = key_out[1];
            if (acc && j < TOTAL) mdl_lfsr = step(mdl_lfsr);
            if (j == extra_at) begin
                start   = 1'b1;
                key_sel = extra_sel;
            end else begin
                start   = 1'b0;
                key_sel = 3'($urandom);
            end
            if (j == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst      = 1'b0;
                mdl_lfsr = SD;
                check("rst_key_out", 32'(key_out), 32'h7);
                check("rst_busy", 32'(busy), 32'h0);
                check("rst_done", 32'(done), 32'h0);
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int bc, dc;
        tbl[0] = '{3'b010, -1,  3'b000, -1,     TOTAL, 1};
        tbl[1] = '{3'b010, 50,  3'b001, -1,     TOTAL, 1};
        tbl[2] = '{3'b000, -1,  3'b000, -1,     0,     0};
        tbl[3] = '{3'b101, TOTAL - 1, 3'b111, -1, TOTAL, 1};
        tbl[4] = '{3'b111, 0,   3'b010, -1,     TOTAL, 1};
        tbl[5] = '{3'b010, -1,  3'b000, B + 40, B + 41, 0};

        // Reset with a start held during it: nothing may happen
        rst      = 1'b1;
        start    = 1'b1;
        key_sel  = 3'b111;
        mdl_lfsr = SD;
        repeat (3) @(negedge clk);
        check("reset_key_out", 32'(key_out), 32'h7);
        check("reset_busy", 32'(busy), 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_key_out", 32'(key_out), 32'h7);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_done", 32'(done), 32'h0);
        end

        for (int t = 0; t < 6; t++) begin
            run_seq(tbl[t].sel, tbl[t].extra_at, tbl[t].extra_sel, tbl[t].rst_at, bc, dc, pat_now);
            check($sformatf("busy_cycles[%0d]", t), 32'(bc), 32'(tbl[t].exp_busy));
            check($sformatf("done_count[%0d]", t), 32'(dc), 32'(tbl[t].exp_done));
            if (t == 0) pat_first = pat_now;
        end

        // After the mid-sequence reset the LFSR is reseeded: same press bounce as the first run
        run_seq(3'b010, -1, 3'b000, -1, bc, dc, pat_now);
        check("reseed_pattern", pat_now[31:0], pat_first[31:0]);
        check("reseed_done", 32'(dc), 32'd1);
`ifdef KEY_EMU_BOUNCE_EN
        begin
            int rises = 0;
            for (int k = 1; k < B; k++) if (!pat_first[k-1] && pat_first[k]) rises++;
            check("pbnc_has_rise", 32'(rises != 0), 32'd1);
        end
`else
        check("pbnc_clean_low", pat_first[31:0], 32'h0);
`endif

        for (int r = 0; r < 6; r++) begin
            logic [2:0] s;
            s = 3'($urandom_range(1, 7));
            run_seq(s, $urandom_range(0, TOTAL - 1), 3'($urandom), -1, bc, dc, pat_now);
            check("rand_busy_cycles", 32'(bc), 32'(TOTAL));
            check("rand_done_count", 32'(dc), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
